// File: rtl/axi_sram_slave_pkg.sv
// Shared types and constants for the AXI4-to-SRAM responder.
// Bus widths match the interconnect's slave-side view (extended ID).
package axi_sram_slave_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_STRB_BITS = 4;

    localparam int SRAM_AW_DEFAULT = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_LATCH,
        RD_DATA,
        WR,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axi_sram_slave.sv
// AXI4 responder in front of one single-port synchronous SRAM.
// One burst at a time; reads win when AR and AW arrive together.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int SRAM_AW = SRAM_AW_DEFAULT
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,

    input  logic [AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]               ARBURST_S,
    input  logic                     ARVALID_S,
    output logic                     ARREADY_S,

    output logic [AXI_IDS_BITS-1:0]  RID_S,
    output logic [AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]               RRESP_S,
    output logic                     RLAST_S,
    output logic                     RVALID_S,
    input  logic                     RREADY_S,

    input  logic [AXI_IDS_BITS-1:0]  AWID_S,
    input  logic [AXI_ADDR_BITS-1:0] AWADDR_S,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN_S,
    input  logic [AXI_SIZE_BITS-1:0] AWSIZE_S,
    input  logic [1:0]               AWBURST_S,
    input  logic                     AWVALID_S,
    output logic                     AWREADY_S,

    input  logic [AXI_DATA_BITS-1:0] WDATA_S,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_S,
    input  logic                     WLAST_S,
    input  logic                     WVALID_S,
    output logic                     WREADY_S,

    output logic [AXI_IDS_BITS-1:0]  BID_S,
    output logic [1:0]               BRESP_S,
    output logic                     BVALID_S,
    input  logic                     BREADY_S,

    output logic                     CS,
    output logic                     OE,
    output logic [3:0]               WEB,
    output logic [SRAM_AW-1:0]       A,
    output logic [31:0]              DI,
    input  logic [31:0]              DO
);

    state_t                    state;
    logic [AXI_IDS_BITS-1:0]   id_q;
    logic [SRAM_AW-1:0]        addr_q;
    logic [AXI_LEN_BITS-1:0]   len_q;
    logic [AXI_LEN_BITS-1:0]   beat_q;
    logic [31:0]               rdata_q;

    // Size, burst type, write length and byte-offset bits play no part:
    // every beat is a full word, bursts are INCR and WLAST ends a write.
    logic unused_inputs;
    assign unused_inputs = ^{ARSIZE_S, ARBURST_S, AWSIZE_S, AWBURST_S, AWLEN_S,
                             ARADDR_S[1:0], ARADDR_S[AXI_ADDR_BITS-1:SRAM_AW+2],
                             AWADDR_S[1:0], AWADDR_S[AXI_ADDR_BITS-1:SRAM_AW+2]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ARVALID_S) begin
                        id_q   <= ARID_S;
                        addr_q <= ARADDR_S[SRAM_AW+1:2];
                        len_q  <= ARLEN_S;
                        beat_q <= '0;
                        state  <= RD_ADDR;
                    end else if (AWVALID_S) begin
                        id_q   <= AWID_S;
                        addr_q <= AWADDR_S[SRAM_AW+1:2];
                        state  <= WR;
                    end
                end
                RD_ADDR: state <= RD_LATCH;
                // DO is valid one cycle after the address cycle; hold it so
                // RDATA stays put however long the master stalls.
                RD_LATCH: begin
                    rdata_q <= DO;
                    state   <= RD_DATA;
                end
                RD_DATA: begin
                    if (RREADY_S) begin
                        if (beat_q == len_q) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                            beat_q <= beat_q + 1'b1;
                            state  <= RD_ADDR;
                        end
                    end
                end
                WR: begin
                    if (WVALID_S) begin
                        addr_q <= addr_q + 1'b1;
                        if (WLAST_S) state <= WR_RESP;
                    end
                end
                WR_RESP: if (BREADY_S) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ARREADY_S = 1'b0;
        AWREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        CS        = 1'b0;
        OE        = 1'b0;
        WEB       = 4'hF;
        A         = '0;
        DI        = '0;
        case (state)
            IDLE: begin
                ARREADY_S = 1'b1;
                AWREADY_S = !ARVALID_S;
            end
            RD_ADDR, RD_LATCH: begin
                CS = 1'b1;
                OE = 1'b1;
                A  = addr_q;
            end
            RD_DATA: RVALID_S = 1'b1;
            WR: begin
                WREADY_S = 1'b1;
                if (WVALID_S) begin
                    CS  = 1'b1;
                    WEB = ~WSTRB_S;
                    A   = addr_q;
                    DI  = WDATA_S;
                end
            end
            WR_RESP: BVALID_S = 1'b1;
            default: ;
        endcase
    end

    assign RID_S   = id_q;
    assign RDATA_S = rdata_q;
    assign RRESP_S = RESP_OKAY;
    assign RLAST_S = (state == RD_DATA) && (beat_q == len_q);
    assign BID_S   = id_q;
    assign BRESP_S = RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: SRAM model, transaction-level reference memory
// with a per-cycle monitor, and directed AXI traffic with literal checks.
module tb_axi_sram_slave;

    localparam int DEPTH = 16384;

    logic        ACLK;
    logic        ARESETn;
    logic [7:0]  ARID_S, AWID_S, RID_S, BID_S;
    logic [31:0] ARADDR_S, AWADDR_S;
    logic [3:0]  ARLEN_S, AWLEN_S;
    logic [2:0]  ARSIZE_S, AWSIZE_S;
    logic [1:0]  ARBURST_S, AWBURST_S;
    logic        ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S;
    logic [31:0] RDATA_S, WDATA_S;
    logic [1:0]  RRESP_S, BRESP_S;
    logic        RLAST_S, RVALID_S, RREADY_S;
    logic [3:0]  WSTRB_S;
    logic        WLAST_S, WVALID_S, WREADY_S;
    logic        BVALID_S, BREADY_S;
    logic        CS, OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO;

    axi_sram_slave #(.SRAM_AW(14)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
        .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
        .WREADY_S(WREADY_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc;
    always @(posedge ACLK) cyc <= cyc + 1;

    int vectors;
    int miscompares;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Synchronous SRAM: byte writes when CS with any WEB low, registered read.
    logic [31:0] sram [DEPTH];
    initial begin
        DO = '0;
        for (int i = 0; i < DEPTH; i++) sram[i] = '0;
        forever begin
            @(posedge ACLK);
            if (CS) begin
                for (int b = 0; b < 4; b++)
                    if (!WEB[b]) sram[A][8*b +: 8] = DI[8*b +: 8];
                if (OE) DO <= sram[A];
            end
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
        logic [13:0] addr;
    } rbeat_t;

    rbeat_t      rq [$];
    logic [31:0] gmem [DEPTH];
    logic        rd_busy, wr_busy, w_open, r_wait, exp_cs, last_beat;
    int          r_due;
    logic [13:0] w_addr, wa;
    logic [7:0]  w_id;

    // Reference model: AXI-level memory plus expected beat queue and
    // latency bookkeeping, checked against the DUT every falling edge.
    initial begin
        for (int i = 0; i < DEPTH; i++) gmem[i] = '0;
        rd_busy = 0; wr_busy = 0; w_open = 0; r_wait = 0; r_due = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                check_output("rst_arready", ARREADY_S, 1'b1);
                check_output("rst_awready", AWREADY_S, !ARVALID_S);
                check_output("rst_valids", {RVALID_S, BVALID_S, WREADY_S}, 3'b000);
                check_output("rst_ids", {RID_S, BID_S, RDATA_S, RLAST_S}, '0);
                check_output("rst_sram", {CS, OE, WEB, A, DI}, {2'b00, 4'hF, 14'h0, 32'h0});
                rq.delete();
                rd_busy = 0; wr_busy = 0; w_open = 0; r_wait = 0;
            end else begin
                if (!rd_busy && !wr_busy) begin
                    check_output("idle_arready", ARREADY_S, 1'b1);
                    check_output("idle_awready", AWREADY_S, !ARVALID_S);
                    check_output("idle_quiet", {RVALID_S, WREADY_S, BVALID_S, CS, OE, WEB}, {5'b0, 4'hF});
                end else begin
                    check_output("busy_addr_ready", {ARREADY_S, AWREADY_S}, 2'b00);
                end
                if (rd_busy) begin
                    exp_cs = r_wait && (cyc < r_due);
                    check_output("rd_cs_oe", {CS, OE, WEB}, {exp_cs, exp_cs, 4'hF});
                    check_output("rd_no_write", {WREADY_S, BVALID_S}, 2'b00);
                    if (exp_cs) check_output("rd_addr", A, rq[0].addr);
                    if (r_wait) begin
                        check_output("r_latency", RVALID_S, cyc == r_due);
                        if (cyc == r_due) r_wait = 0;
                    end else begin
                        check_output("r_hold", RVALID_S, 1'b1);
                    end
                    if (RVALID_S) begin
                        check_output("r_beat", {RDATA_S, RID_S, RLAST_S, RRESP_S},
                                     {rq[0].data, rq[0].id, rq[0].last, 2'b00});
                        if (RREADY_S) begin
                            last_beat = rq[0].last;
                            void'(rq.pop_front());
                            if (last_beat) rd_busy = 0;
                            else begin
                                r_wait = 1;
                                r_due  = cyc + 3;
                            end
                        end
                    end
                end
                if (wr_busy) begin
                    check_output("wr_no_read", {RVALID_S, OE}, 2'b00);
                    if (w_open) begin
                        check_output("w_ready", {WREADY_S, BVALID_S}, 2'b10);
                        if (WVALID_S) begin
                            check_output("w_sram", {CS, WEB, A, DI}, {1'b1, ~WSTRB_S, w_addr, WDATA_S});
                            for (int b = 0; b < 4; b++)
                                if (WSTRB_S[b]) gmem[w_addr][8*b +: 8] = WDATA_S[8*b +: 8];
                            w_addr = w_addr + 14'd1;
                            if (WLAST_S) w_open = 0;
                        end else begin
                            check_output("w_idle_cs", CS, 1'b0);
                        end
                    end else begin
                        check_output("b_phase", {WREADY_S, CS, BVALID_S}, 3'b001);
                        check_output("b_resp", {BID_S, BRESP_S}, {w_id, 2'b00});
                        if (BREADY_S) wr_busy = 0;
                    end
                end
                if (ARVALID_S && ARREADY_S) begin
                    wa = ARADDR_S[15:2];
                    for (int i = 0; i <= int'(ARLEN_S); i++) begin
                        rq.push_back('{gmem[wa], ARID_S, (i == int'(ARLEN_S)), wa});
                        wa = wa + 14'd1;
                    end
                    rd_busy = 1; r_wait = 1; r_due = cyc + 3;
                end else if (AWVALID_S && AWREADY_S) begin
                    wr_busy = 1; w_open = 1;
                    w_addr  = AWADDR_S[15:2];
                    w_id    = AWID_S;
                end
            end
        end
    end

    logic [31:0] wd [4];
    logic [3:0]  ws [4];
    logic [31:0] rd [4];
    int          got;
    logic [7:0]  bid;
    logic        obs_cs;
    logic [3:0]  obs_web;
    logic [13:0] obs_a;
    logic [31:0] obs_di;
    logic        hs;

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        logic ok;
        ok = 0;
        ARID_S = id; ARADDR_S = addr; ARLEN_S = len; ARSIZE_S = 3'd2; ARBURST_S = 2'b01;
        ARVALID_S = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            ok = ARREADY_S;
            step();
        end
        ARVALID_S = 0;
        check_output("ar_handshake", ok, 1'b1);
    endtask

    task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        logic ok;
        ok = 0;
        AWID_S = id; AWADDR_S = addr; AWLEN_S = len; AWSIZE_S = 3'd2; AWBURST_S = 2'b01;
        AWVALID_S = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            ok = AWREADY_S;
            step();
        end
        AWVALID_S = 0;
        check_output("aw_handshake", ok, 1'b1);
    endtask

    task automatic do_w(input int n);
        logic ok;
        for (int b = 0; b < n; b++) begin
            WDATA_S = wd[b]; WSTRB_S = ws[b]; WLAST_S = (b == n - 1); WVALID_S = 1;
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge ACLK);
                ok = WREADY_S;
                if (ok && b == 0) {obs_cs, obs_web, obs_a, obs_di} = {CS, WEB, A, DI};
                step();
            end
            check_output("w_handshake", ok, 1'b1);
        end
        WVALID_S = 0; WLAST_S = 0;
    endtask

    task automatic do_b(output logic [7:0] id);
        logic ok;
        ok = 0; id = '0;
        BREADY_S = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge ACLK);
            ok = BVALID_S;
            if (ok) id = BID_S;
            step();
        end
        BREADY_S = 0;
        check_output("b_handshake", ok, 1'b1);
    endtask

    task automatic collect_r(input int n, input logic toggle);
        got = 0;
        for (int i = 0; i < 4; i++) rd[i] = '0;
        for (int c = 0; c < 200 && got < n; c++) begin
            RREADY_S = toggle ? c[0] : 1'b1;
            @(negedge ACLK);
            if (RVALID_S && RREADY_S) begin
                rd[got] = RDATA_S;
                got++;
            end
            step();
        end
        RREADY_S = 0;
        check_output("r_count", got, n);
    endtask

    task automatic apply_stimulus();
        // Single full-word write, then read back.
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_aw(8'h42, 32'h0000_0010, 4'd0);
        do_w(1);
        check_output("wr1_sram", {obs_cs, obs_web, obs_a, obs_di}, {1'b1, 4'h0, 14'd4, 32'hDEADBEEF});
        do_b(bid);
        check_output("wr1_bid", bid, 8'h42);
        do_ar(8'h17, 32'h10, 4'd0);
        collect_r(1, 1'b0);
        check_output("rd1_data", rd[0], 32'hDEADBEEF);

        // Partial write over the same word.
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        do_aw(8'h43, 32'h10, 4'd0);
        do_w(1);
        check_output("wr2_web", obs_web, 4'b1010);
        do_b(bid);
        do_ar(8'h18, 32'h10, 4'd0);
        collect_r(1, 1'b0);
        check_output("rd2_data", rd[0], 32'hDE22BE44);

        // Four-beat write wrapping the top of the SRAM, read with stalls.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hCAFE_0000 + i;
            ws[i] = 4'hF;
        end
        do_aw(8'h50, 32'h0000_FFF8, 4'd3);
        do_w(4);
        do_b(bid);
        check_output("wr3_bid", bid, 8'h50);
        do_ar(8'h51, 32'h0000_FFF8, 4'd3);
        collect_r(4, 1'b1);
        check_output("rd3_beat0", rd[0], 32'hCAFE_0000);
        check_output("rd3_beat3", rd[3], 32'hCAFE_0003);
        do_ar(8'h52, 32'h0, 4'd0);
        collect_r(1, 1'b0);
        check_output("rd_wrap0", rd[0], 32'hCAFE_0002);
        do_ar(8'h53, 32'h4, 4'd0);
        collect_r(1, 1'b0);
        check_output("rd_wrap1", rd[0], 32'hCAFE_0003);

        // Simultaneous AR and AW: the read goes first.
        AWID_S = 8'h60; AWADDR_S = 32'h20; AWLEN_S = 4'd0; AWVALID_S = 1;
        ARID_S = 8'h61; ARADDR_S = 32'h10; ARLEN_S = 4'd0; ARVALID_S = 1;
        @(negedge ACLK);
        check_output("simul_ready", {ARREADY_S, AWREADY_S}, 2'b10);
        step();
        ARVALID_S = 0;
        collect_r(1, 1'b0);
        check_output("simul_rdata", rd[0], 32'hDE22BE44);
        wd[0] = 32'h5A5A_A5A5; ws[0] = 4'hF;
        do_aw(8'h60, 32'h20, 4'd0);
        do_w(1);
        do_b(bid);
        check_output("simul_bid", bid, 8'h60);
        do_ar(8'h62, 32'h20, 4'd0);
        collect_r(1, 1'b0);
        check_output("simul_readback", rd[0], 32'h5A5A_A5A5);

        // Reset while beat 2 of a 4-beat read is on the bus.
        do_ar(8'h70, 32'h0000_FFF8, 4'd3);
        RREADY_S = 1;
        hs = 0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge ACLK);
            hs = RVALID_S;
            step();
        end
        RREADY_S = 0;
        hs = 0;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge ACLK);
            hs = RVALID_S;
            if (!hs) step();
        end
        check_output("rst_beat2_seen", hs, 1'b1);
        #2 ARESETn = 0;
        #1 check_output("rst_rvalid_drop", {RVALID_S, CS}, 2'b00);
        @(negedge ACLK);
        #1 ARESETn = 1;
        step();
        check_output("post_rst_arready", ARREADY_S, 1'b1);
        do_ar(8'h71, 32'h10, 4'd0);
        collect_r(1, 1'b0);
        check_output("post_rst_read", rd[0], 32'hDE22BE44);
    endtask

    initial begin
        ARESETn = 0;
        ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0; ARVALID_S = 0;
        AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0; AWBURST_S = '0; AWVALID_S = 0;
        WDATA_S = '0; WSTRB_S = '0; WLAST_S = 0; WVALID_S = 0;
        RREADY_S = 0; BREADY_S = 0;
        vectors = 0; miscompares = 0;
        step();
        ARVALID_S = 1;
        step();
        ARVALID_S = 0;
        step();
        ARESETn = 1;
        step();
        apply_stimulus();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        check_output("watchdog", 1'b0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
